// File: rtl/bf_sweep_ctrl.sv
// bf_sweep_ctrl: sweeps the 8 input vectors of a 3-input function under test,
// holding each for DWELL cycles, and captures the sampled outputs as a truth table.
// Ports: clk, rst (async, active-high), start, abort, f_out, expected_tt[7:0]
//        -> inA/inB/inC (vector drive), busy, done, tt[7:0], tt_valid, mismatch.
// Optional: define BF_SWEEP_CMP_EN to register mismatch = (tt != expected_tt)
//           at sweep end; otherwise mismatch is tied low.
module bf_sweep_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       f_out,
    input  logic [7:0] expected_tt,
    output logic       inA,
    output logic       inB,
    output logic       inC,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       tt_valid,
    output logic       mismatch
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    tt_smp;
    logic          last_smp;

    // truth table including the sample taken at this edge
    always_comb begin
        tt_smp      = tt;
        tt_smp[idx] = f_out;
    end

    assign last_smp = (state == APPLY) && !abort
                    && (cnt == CNT_MAX) && (idx == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= 3'd0;
            cnt           <= '0;
            {inA,inB,inC} <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            tt            <= 8'h00;
            tt_valid      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state         <= APPLY;
                        idx           <= 3'd0;
                        cnt           <= '0;
                        {inA,inB,inC} <= 3'd0;
                        busy          <= 1'b1;
                        tt            <= 8'h00;
                        tt_valid      <= 1'b0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        // partial tt is kept, sweep is not reported
                        state         <= IDLE;
                        idx           <= 3'd0;
                        cnt           <= '0;
                        {inA,inB,inC} <= 3'd0;
                        busy          <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        tt  <= tt_smp;
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            state         <= DONE;
                            idx           <= 3'd0;
                            {inA,inB,inC} <= 3'd0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            tt_valid      <= 1'b1;
                        end else begin
                            idx           <= idx + 3'd1;
                            {inA,inB,inC} <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BF_SWEEP_CMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (state == IDLE && start) begin
            mismatch <= 1'b0;
        end else if (last_smp) begin
            mismatch <= (tt_smp != expected_tt);
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = (^expected_tt) ^ last_smp;
    assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_bf_sweep_ctrl.sv
// tb_bf_sweep_ctrl: directed bench for bf_sweep_ctrl with DWELL=4 (majority)
// and DWELL=1 (3-input xor) instances sharing one clock.
module tb_bf_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] expected_tt = 8'hE8;
    logic       inA, inB, inC, busy, done, tt_valid, mismatch;
    logic [7:0] tt;
    logic       f_out;

    logic       start1 = 1'b0;
    logic       inA1, inB1, inC1, busy1, done1, tt_valid1, mismatch1;
    logic [7:0] tt1;
    logic       f_out1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign f_out  = (inA & inB) | (inA & inC) | (inB & inC);
    assign f_out1 = inA1 ^ inB1 ^ inC1;

    bf_sweep_ctrl #(.DWELL(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .f_out(f_out), .expected_tt(expected_tt),
        .inA(inA), .inB(inB), .inC(inC), .busy(busy), .done(done),
        .tt(tt), .tt_valid(tt_valid), .mismatch(mismatch)
    );

    bf_sweep_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
        .f_out(f_out1), .expected_tt(8'h96),
        .inA(inA1), .inB(inB1), .inC(inC1), .busy(busy1), .done(done1),
        .tt(tt1), .tt_valid(tt_valid1), .mismatch(mismatch1)
    );

    // Start a sweep on one instance and count edges until done (-1 on timeout).
    // Edge 0 is the edge that accepts start. Optionally re-pulses start.
    task automatic sweep(input bit sel, input int budget, input int restart_at,
                         output int n, output bit vec_ok);
        vec_ok = 1'b1;
        if (sel) start1 = 1'b1;
        else start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        start = 1'b0;
        start1 = 1'b0;
        while (n < budget) begin
            if (!sel && n < 32 && {inA,inB,inC} !== 3'(n / 4)) vec_ok = 1'b0;
            if (n + 1 == restart_at) start = 1'b1;
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (sel ? done1 : done) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({busy,done,tt_valid,mismatch,inA,inB,inC} !== 7'd0) begin
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy,done,tt_valid,mismatch,inA,inB,inC});
        end else passed++;
        total++;
        if (tt !== 8'h00 || tt1 !== 8'h00) begin
            $display("FAIL reset_tt: got %h/%h want 00/00", tt, tt1);
        end else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL idle_abort_ignored: busy got %b want 0", busy);
        end else passed++;
    endtask

    task automatic test_majority();
        int n;
        bit ok;
        expected_tt = 8'hE8;
        sweep(1'b0, 60, -1, n, ok);
        total++;
        if (n != 32) $display("FAIL maj_latency: got %0d want 32", n);
        else passed++;
        total++;
        if (!ok) $display("FAIL maj_vectors: got bad want idx/4");
        else passed++;
        total++;
        if (tt !== 8'hE8 || tt_valid !== 1'b1) begin
            $display("FAIL maj_tt: got %h/%b want e8/1", tt, tt_valid);
        end else passed++;
        total++;
        if (mismatch !== 1'b0) begin
            $display("FAIL maj_cmp_match: got %b want 0", mismatch);
        end else passed++;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || tt_valid !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL maj_after: got d%b v%b b%b want d0 v1 b0",
                     done, tt_valid, busy);
        end else passed++;
    endtask

    task automatic test_mismatch();
        int n;
        bit ok;
        logic want;
`ifdef BF_SWEEP_CMP_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        expected_tt = 8'hE9;
        sweep(1'b0, 60, -1, n, ok);
        total++;
        if (n != 32 || tt !== 8'hE8) begin
            $display("FAIL cmp_sweep: got %0d/%h want 32/e8", n, tt);
        end else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (mismatch !== want) begin
            $display("FAIL cmp_mismatch: got %b want %b", mismatch, want);
        end else passed++;
        expected_tt = 8'hE8;
    endtask

    task automatic test_abort();
        int seen;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (tt_valid !== 1'b0 || busy !== 1'b1 || mismatch !== 1'b0) begin
            $display("FAIL abort_startclr: got v%b b%b m%b want v0 b1 m0",
                     tt_valid, busy, mismatch);
        end else passed++;
        repeat (8) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || tt_valid !== 1'b0 || done !== 1'b0) begin
            $display("FAIL abort_idle: got b%b v%b d%b want b0 v0 d0",
                     busy, tt_valid, done);
        end else passed++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL abort_nodone: got %0d want 0", seen);
        else passed++;
    endtask

    task automatic test_restart_ignored();
        int n;
        bit ok;
        sweep(1'b0, 60, 5, n, ok);
        total++;
        if (n != 32 || tt !== 8'hE8 || !ok) begin
            $display("FAIL restart_ignored: got %0d/%h/%b want 32/e8/1",
                     n, tt, ok);
        end else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b1 || tt_valid !== 1'b0) begin
            $display("FAIL start_wins: got b%b v%b want b1 v0", busy, tt_valid);
        end else passed++;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        total++;
        if (tt !== 8'h08) $display("FAIL mid_partial: got %h want 08", tt);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({busy,done,tt_valid,mismatch,inA,inB,inC} !== 7'd0
            || tt !== 8'h00) begin
            $display("FAIL mid_reset: got %b/%h want 0000000/00",
                     {busy,done,tt_valid,mismatch,inA,inB,inC}, tt);
        end else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL mid_wait: got b%b d%b want b0 d0", busy, done);
        end else passed++;
        sweep(1'b0, 60, -1, n, ok);
        total++;
        if (n != 32 || tt !== 8'hE8 || tt_valid !== 1'b1 || !ok) begin
            $display("FAIL mid_resweep: got %0d/%h/%b want 32/e8/1",
                     n, tt, tt_valid);
        end else passed++;
    endtask

    task automatic test_dwell1();
        int n;
        bit ok;
        sweep(1'b1, 30, -1, n, ok);
        total++;
        if (n != 8) $display("FAIL d1_latency: got %0d want 8", n);
        else passed++;
        total++;
        if (tt1 !== 8'h96 || tt_valid1 !== 1'b1) begin
            $display("FAIL d1_tt: got %h/%b want 96/1", tt1, tt_valid1);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        @(posedge clk); #1;
        sweep(1'b1, 30, -1, n, ok);
        total++;
        if (n != 8 || tt1 !== 8'h96) begin
            $display("FAIL b2b: got %0d/%h want 8/96", n, tt1);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_majority();
        test_mismatch();
        test_abort();
        test_restart_ignored();
        test_start_abort_idle();
        test_reset_mid();
        test_dwell1();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bf_sweep_ctrl.md
BF_SWEEP_CTRL -- requirements
Module: bf_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, meaning the number of clock cycles each input vector is held; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: requests a sweep; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous cancel of a running sweep.
REQ-006 The block SHALL have port f_out, input, 1 bit: output of the 3-input function under test.
REQ-007 The block SHALL have port expected_tt, input, 8 bits: expected truth table, bit i = f(i).
REQ-008 The block SHALL have ports inA, inB, inC, output, 1 bit each: drive the function under test; inA = idx[2], inB = idx[1], inC = idx[0].
REQ-009 The block SHALL have port busy, output, 1 bit: high in APPLY.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-011 The block SHALL have port tt, output, 8 bits: captured truth table.
REQ-012 The block SHALL have port tt_valid, output, 1 bit: tt holds a complete sweep.
REQ-013 The block SHALL have port mismatch, output, 1 bit: tt differs from expected_tt.

Function
REQ-014 The block SHALL implement three states (IDLE, APPLY, DONE), a 3-bit vector index idx and a dwell counter cnt sized to hold DWELL-1.
REQ-015 In IDLE, the block SHALL keep inA/inB/inC at 0 and busy at 0, and it SHALL ignore abort.
REQ-016 When start=1 in IDLE, the block SHALL, at that edge, go to APPLY, set idx=0, set cnt=0, clear tt to 0, clear tt_valid and clear mismatch.
REQ-017 In APPLY, on each edge, the block SHALL increment cnt while cnt < DWELL-1.
REQ-018 In APPLY, at the edge where cnt = DWELL-1, the block SHALL write f_out into tt[idx] and set cnt=0.
REQ-019 At that sampling edge, if idx < 7 the block SHALL increment idx; if idx = 7 it SHALL go to DONE.
REQ-020 The inputs inA/inB/inC SHALL be registered and equal idx throughout APPLY, so that f_out is sampled DWELL cycles after the vector changes.
REQ-021 In DONE, the block SHALL assert done for exactly one cycle, set tt_valid=1 and return to IDLE on the next edge; tt_valid SHALL hold until the next accepted start or reset.
REQ-022 The block SHALL pulse done 8*DWELL edges after the edge that accepts start, e.g. 32 edges for DWELL=4 and 8 edges for DWELL=1.
REQ-023 The block SHALL ignore start while in APPLY or DONE; no restart and no state change.
REQ-024 When abort=1 in APPLY, the block SHALL return to IDLE at that edge, with tt_valid=0, done not asserted and tt holding its partial contents; abort SHALL take priority over sampling in the same cycle.
REQ-025 When start and abort are both high in IDLE, start SHALL win.
REQ-026 The block SHALL keep tt stable while in IDLE and DONE.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, idx=0, cnt=0, inA=inB=inC=0, tt=8'h00, tt_valid=0, busy=0, done=0 and mismatch=0, regardless of the clock.
REQ-028 A reset asserted mid-sweep SHALL discard the sweep; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-029 With macro BF_SWEEP_CMP_EN defined, mismatch SHALL be registered at the DONE edge as (tt with final sample != expected_tt) and SHALL hold until the next accepted start or reset.
REQ-030 Without BF_SWEEP_CMP_EN, mismatch SHALL be tied to 0, expected_tt SHALL be unused, and all other behaviour SHALL be unchanged.

Verification
REQ-031 A bench SHALL cover this scenario: DWELL=4, f_out=majority(inA,inB,inC), start pulse -> done pulse 32 edges later, tt=8'hE8, tt_valid=1.
REQ-032 A bench SHALL cover this scenario: CMP_EN defined, majority function, expected_tt=8'hE8 -> mismatch=0; rerun with expected_tt=8'hE9 -> mismatch=1.
REQ-033 A bench SHALL cover this scenario: abort at edge 10 after start -> IDLE next cycle, busy=0, tt_valid=0, no done pulse.
REQ-034 A bench SHALL cover this scenario: start re-pulsed at edge 5 of a sweep -> ignored, done still at edge 32, tt=8'hE8.
REQ-035 A bench SHALL cover this scenario: rst asserted mid-sweep (between clock edges) -> all outputs 0 immediately; a new start after release gives a full correct sweep.
REQ-036 A bench SHALL cover this scenario: DWELL=1, f_out=inA^inB^inC -> done 8 edges after start, tt=8'h96.
